// File: rtl/sync_fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
package sync_fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int unsigned ARB_NUM_REQ   = 4;
  localparam int unsigned ARB_MAX_BURST = 4;

endpackage

// File: rtl/sync_fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first set request after last_grant, with wrap-around.
module rr_pick #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = $clog2(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] last_grant_i,
  output logic           found_o,
  output logic [IDW-1:0] winner_o
);

  localparam logic [IDW:0] N_W = (IDW+1)'(N);

  logic [IDW-1:0] start;
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IDW-1:0] off;
  logic [IDW:0]   sum;

  // Search starts one past the previous winner.
  always_comb begin
    start = (last_grant_i == IDW'(N - 1)) ? '0 : last_grant_i + IDW'(1);
  end

  // Rotate so the first candidate lands at bit 0.
  assign dbl = {req_i, req_i};
  assign rot = N'(dbl >> start);

  // Lowest set bit of the rotated vector.
  always_comb begin
    found_o = 1'b0;
    off     = '0;
    for (int j = int'(N) - 1; j >= 0; j--) begin
      if (rot[j]) begin
        found_o = 1'b1;
        off     = IDW'(j);
      end
    end
  end

  // Undo the rotation modulo N.
  always_comb begin
    sum      = {1'b0, start} + {1'b0, off};
    winner_o = (sum >= N_W) ? IDW'(sum - N_W) : IDW'(sum);
  end

endmodule

// File: rtl/sync_fifo_wr_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one sync_fifo write port.
module sync_fifo_wr_arbiter
  import sync_fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = ARB_NUM_REQ,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = ARB_MAX_BURST,
  parameter int unsigned ID_WIDTH   = $clog2(NUM_REQ),
  parameter int unsigned CNT_WIDTH  = $clog2(MAX_BURST + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic                          grant_valid,
  output logic [ID_WIDTH-1:0]           grant_id
);

  arb_state_e          state_q, state_d;
  logic [ID_WIDTH-1:0] owner_q, owner_d;
  logic [ID_WIDTH-1:0] last_grant_q, last_grant_d;
  logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;

  logic                pick_found;
  logic [ID_WIDTH-1:0] pick_id;
  logic [ID_WIDTH-1:0] sel;
  logic                accept;

  rr_pick #(
    .N   (NUM_REQ),
    .IDW (ID_WIDTH)
  ) u_rr_pick (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .found_o      (pick_found),
    .winner_o     (pick_id)
  );

  // Transfer decision: who is selected and whether a beat moves this cycle.
  always_comb begin
    sel    = owner_q;
    accept = 1'b0;
    if (state_q == IDLE) begin
      sel    = pick_id;
      accept = pick_found && !fifo_full;
    end else begin
      accept = req_valid[owner_q] && !fifo_full;
    end
  end

  // State register; reset drops any ownership at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_grant_q <= ID_WIDTH'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  // Next-state: grant from IDLE, count beats, release on drop or burst limit.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (MAX_BURST == 1) begin
            last_grant_d = sel;
          end else begin
            state_d    = BURST;
            owner_d    = sel;
            beat_cnt_d = CNT_WIDTH'(1);
          end
        end
      end
      BURST: begin
        if (!req_valid[owner_q]) begin
          state_d      = IDLE;
          last_grant_d = owner_q;
          beat_cnt_d   = '0;
        end else if (accept) begin
          if (beat_cnt_q + CNT_WIDTH'(1) == CNT_WIDTH'(MAX_BURST)) begin
            state_d      = IDLE;
            last_grant_d = owner_q;
            beat_cnt_d   = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: zero-latency write path, forced quiet while reset is high.
  always_comb begin
    req_ready   = '0;
    fifo_wr_en  = 1'b0;
    fifo_din    = '0;
    grant_valid = 1'b0;
    grant_id    = '0;
    if (!reset) begin
      if (accept) begin
        req_ready  = NUM_REQ'(1) << sel;
        fifo_wr_en = 1'b1;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
          if (sel == ID_WIDTH'(i)) fifo_din = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      if (state_q == BURST) begin
        grant_valid = 1'b1;
        grant_id    = owner_q;
      end
    end
  end

endmodule

// File: doc/sync_fifo_wr_arbiter.md
Name: sync_fifo_wr_arbiter

Overview:
- Shares the single write port of a sync_fifo between NUM_REQ producers.
- Uses round-robin arbitration with bounded bursts: a winner keeps the port for up to MAX_BURST consecutive beats, then priority rotates.
- Sits directly in front of sync_fifo: drives its wr_en/din and observes its full flag.
- Producers use a valid/ready handshake; a beat transfers when valid && ready.

Parameters:
- NUM_REQ, 4: number of requesters, >= 2.
- DATA_WIDTH, 8: beat width; must equal the FIFO's DATA_WIDTH.
- MAX_BURST, 4: maximum consecutive beats per grant, >= 1.
- ID_WIDTH, $clog2(NUM_REQ): requester index width.
- CNT_WIDTH, $clog2(MAX_BURST+1): burst counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_data  in  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- fifo_full  in  1  full flag from the FIFO.
- fifo_wr_en  out  1  FIFO write enable.
- fifo_din  out  DATA_WIDTH  FIFO write data.
- grant_valid  out  1  a requester currently owns the port (BURST state).
- grant_id  out  ID_WIDTH  owner index; 0 when grant_valid=0.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, named reset.
- Reset state: state=IDLE, last_grant=NUM_REQ-1 (requester 0 has first priority), beat_cnt=0.
- While reset is high: req_ready=0, fifo_wr_en=0, fifo_din=0, grant_valid=0, grant_id=0.
- Reset mid-burst drops ownership immediately; no partial beat is written.
- Output timing: fifo_wr_en, fifo_din and req_ready are combinational from state and inputs. The transfer completes at the same edge on which the FIFO samples wr_en, so latency is zero cycles from accept to FIFO write.
- Write condition: fifo_wr_en is never asserted when fifo_full=1. fifo_wr_en=1 implies exactly one req_ready bit is high and fifo_din equals that requester's data slice.
- IDLE state:
  - Winner = first i with req_valid[i] set, scanning (last_grant+1) mod NUM_REQ upward with wrap-around.
  - If a winner exists and fifo_full=0: accept one beat (req_ready[winner]=1, fifo_wr_en=1).
  - If MAX_BURST=1: last_grant<=winner, stay IDLE.
  - Otherwise: go to BURST with owner<=winner, beat_cnt<=1.
  - If fifo_full=1: no grant, no state change, last_grant unchanged; a full FIFO never locks ownership.
- BURST state (grant_valid=1, grant_id=owner):
  - req_valid[owner]=1 and fifo_full=0: accept a beat, beat_cnt<=beat_cnt+1. If beat_cnt+1==MAX_BURST, go to IDLE and set last_grant<=owner.
  - req_valid[owner]=1 and fifo_full=1: stall; hold owner and beat_cnt, all ready=0.
  - req_valid[owner]=0: release. Go to IDLE, last_grant<=owner, no transfer this cycle. This one-cycle bubble is required behaviour.
- Other requesters' valid never affects BURST state.
- Requesters may drop valid without a transfer; the arbiter treats valid as a level each cycle.
- beat_cnt never exceeds MAX_BURST. owner and last_grant stay in [0, NUM_REQ-1].
- FIFO full/not-full toggling between cycles is handled by the per-cycle gating above.

Decomposition:
- Package sync_fifo_arb_pkg:
  - arb_state_e enum {IDLE, BURST}.
  - Default constants ARB_NUM_REQ=4 and ARB_MAX_BURST=4.
- Sub-module rr_pick (combinational):
  - Inputs: req vector, last_grant.
  - Outputs: found and winner index.
  - Implemented as a rotate, priority-encode, un-rotate.
  - Reused by future read-side schedulers.
- Data mux and FSM stay in the top module.

Test Plan:
1. Reset, then req_valid=4'b0001 for 6 cycles with data 0x10..0x15, FIFO never full -> beats 0x10..0x13 written on consecutive cycles. Cycle 5 re-arbitrates in IDLE and requester 0 wins again (only requester), writing 0x14, 0x15. grant_id=0 throughout BURST.
2. req_valid=4'b1111 held, fifo_full=0 -> owner sequence 0,1,2,3,0, each holding 4 beats. fifo_wr_en is high every cycle except none lost; exactly 20 beats in 20 cycles.
3. Requester 2 in BURST after 2 beats, fifo_full=1 for 3 cycles -> fifo_wr_en=0 and ready=0 for 3 cycles, grant_id stays 2. When full deasserts, 2 more beats follow, then release.
4. Requester 1 owns, drops valid after 1 beat while requester 3 is valid -> one bubble cycle with fifo_wr_en=0, then requester 3 is granted next (last_grant=1).
5. Assert reset mid-burst (owner 2, beat_cnt=2) between clock edges -> fifo_wr_en and req_ready fall immediately. After release with req_valid=4'b0100, requester 2 wins from IDLE and beat_cnt restarts at 1.
6. MAX_BURST=1, NUM_REQ=3, all valid, 9 cycles -> grants 0,1,2,0,1,2,0,1,2; grant_valid stays 0.
